// File: rtl/bias_accum_stage.sv
// bias_accum_stage: per-lane multi-pass accumulator. It adds the layer bias on the
// first pass, saturates to 18 bits, applies an optional ReLU and hands each finished
// output group to the next layer through a one-deep valid/ready output stage.
module bias_accum_stage #(
    parameter int N_adder_tree = 16,
    parameter int ACC_W        = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_adder_tree*18-1:0]   bias,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_adder_tree*18-1:0]   in_data,
    input  logic                         in_last,
    input  logic                         relu_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_adder_tree*18-1:0]   out_data,
    output logic                         sat_flag,
    output logic [15:0]                  group_count
);

    localparam int DW = N_adder_tree * 18;

    // Accumulator limits, held one bit wider so the raw sum can be compared directly.
    localparam logic signed [ACC_W:0]   WIDE_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   WIDE_MIN = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX  = WIDE_MAX[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0] ACC_MIN  = WIDE_MIN[ACC_W-1:0];
    // Output range of the 18-bit result, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] S18_MAX  = ACC_W'(131071);
    localparam logic signed [ACC_W-1:0] S18_MIN  = ACC_W'(-131072);

    // IDLE_ACC: the next accepted beat opens a new group. ACCUM: a group is in progress.
    typedef enum logic {
        IDLE_ACC = 1'b0,
        ACCUM    = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    accept;
    logic                    last_accept;
    logic [DW-1:0]           lane_res;
    logic [N_adder_tree-1:0] sat_acc_vec;
    logic [N_adder_tree-1:0] sat_out_vec;

    // The only stall source is a held output the downstream has not taken yet.
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && in_last;

    // Group state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE_ACC;
        else     state <= state_next;
    end

    // Group state transitions: a last beat closes the group, any other beat opens or continues it.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        state_next = state;
        if (accept) begin
            state_next = in_last ? IDLE_ACC : ACCUM;
        end
    end

    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
        logic signed [17:0]      din;
        logic signed [17:0]      bin;
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W:0]   wide;
        logic signed [ACC_W-1:0] acc_next;
        logic signed [17:0]      res18;
        logic                    acc_clamp;
        logic                    out_clamp;

        assign din = in_data[18*i +: 18];
        assign bin = bias[18*i +: 18];

        // The first beat of a group is seeded with the bias; later beats extend the running sum.
        assign wide = (state == IDLE_ACC) ? ((ACC_W+1)'(din) + (ACC_W+1)'(bin))
                                          : ((ACC_W+1)'(acc) + (ACC_W+1)'(din));

        // Clamp the new running sum into the accumulator range.
        always_comb begin
            acc_next  = wide[ACC_W-1:0];
            acc_clamp = 1'b0;
            if (wide > WIDE_MAX) begin
                acc_next  = ACC_MAX;
                acc_clamp = 1'b1;
            end else if (wide < WIDE_MIN) begin
                acc_next  = ACC_MIN;
                acc_clamp = 1'b1;
            end
        end

        // Reduce the finished sum to 18 bits, then apply ReLU to the clamped value.
        always_comb begin
            res18     = acc_next[17:0];
            out_clamp = 1'b0;
            if (acc_next > S18_MAX) begin
                res18     = 18'h1FFFF;
                out_clamp = 1'b1;
            end else if (acc_next < S18_MIN) begin
                res18     = 18'h20000;
                out_clamp = 1'b1;
            end
            if (relu_en && res18[17]) begin
                res18 = '0;
            end
        end

        // Running sum: cleared on reset and after the last pass so the next group starts clean.
        always_ff @(posedge clk) begin
            if (rst)         acc <= '0;
            else if (accept) acc <= in_last ? '0 : acc_next;
        end

        assign lane_res[18*i +: 18] = res18;
        assign sat_acc_vec[i]       = acc_clamp;
        assign sat_out_vec[i]       = out_clamp;
    end

    // One-deep output stage: load on a last beat, otherwise drain when the downstream accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (last_accept) begin
            out_valid <= 1'b1;
            out_data  <= lane_res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky saturation indicator covering both the accumulator and the 18-bit clamp.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (accept && ((|sat_acc_vec) || (in_last && (|sat_out_vec)))) begin
            sat_flag <= 1'b1;
        end
    end

    // Count groups taken by the downstream; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst)                         group_count <= '0;
        else if (out_valid && out_ready) group_count <= group_count + 16'd1;
    end

endmodule
